fetch_if_id_stage: RTL and testbench



---
 rtl/fetch_if_id_stage.sv | 200 ++++++++++++++++++++
 tb/tb_fetch_if_id_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_if_id_stage.sv
// -----------------------------------------------------------------------------
// fetch_if_id_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the 5-stage RISC-V
// core. It issues one request at a time to a variable-latency instruction
// memory (req/gnt/rvalid), loads returned instructions into IF/ID, honours the
// hazard unit's hold request, and flushes wrong-path work on an EX redirect.
//
// A one-entry skid buffer catches a response that lands while IF/ID is held.
// While the skid buffer is full no new request is issued, so at most one
// instruction is ever waiting behind a held IF/ID.
//
// Ports
//   clk          in   core clock
//   rst          in   synchronous active-high reset
//   if_id_hold   in   1 = keep IF/ID contents, stop PC advance
//   redirect     in   EX branch/jump taken: flush IF/ID and refetch
//   redirect_pc  in   redirect target
//   imem_req     out  fetch request valid
//   imem_addr    out  fetch address (pc_q)
//   imem_gnt     in   memory accepts the request this cycle
//   imem_rvalid  in   response valid
//   imem_rdata   in   response instruction
//   if_id_valid  out  IF/ID holds a real instruction
//   if_id_pc     out  PC of the IF/ID instruction
//   if_id_instr  out  IF/ID instruction (NOP_INSTR when invalid)
// -----------------------------------------------------------------------------
module fetch_if_id_stage #(
  parameter int unsigned            PC_W      = 64,
  parameter int unsigned            INSTR_W   = 32,
  parameter logic [PC_W-1:0]        RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_id_hold,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_id_valid,
  output logic [PC_W-1:0]    if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // one dead cycle after reset
    ST_ISSUE = 2'd1,  // imem_req asserted, waiting for gnt
    ST_WAIT  = 2'd2,  // request accepted, waiting for rvalid
    ST_FULL  = 2'd3   // response parked in skid, waiting for hold release
  } state_e;

  state_e               state_q,       state_d;
  logic [PC_W-1:0]      pc_q,          pc_d;
  logic [PC_W-1:0]      req_pc_q,      req_pc_d;
  logic                 kill_q,        kill_d;
  logic                 skid_valid_q,  skid_valid_d;
  logic [PC_W-1:0]      skid_pc_q,     skid_pc_d;
  logic [INSTR_W-1:0]   skid_instr_q,  skid_instr_d;
  logic                 if_id_valid_q, if_id_valid_d;
  logic [PC_W-1:0]      if_id_pc_q,    if_id_pc_d;
  logic [INSTR_W-1:0]   if_id_instr_q, if_id_instr_d;

  logic accept;   // request handed to memory this cycle
  logic rsp;      // response for the outstanding request this cycle
  logic rsp_wr;   // live response being written into IF/ID or skid

  // Request and address are pure decodes of state/pc registers.
  assign imem_req  = (state_q == ST_ISSUE);
  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_gnt;
  // Responses only count while a request is outstanding; stray ones
  // (e.g. arriving after a reset) are ignored.
  assign rsp       = imem_rvalid & (state_q == ST_WAIT);

  assign if_id_valid = if_id_valid_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_instr = if_id_instr_q;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves it unassigned;
    // otherwise synthesis infers a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    kill_d        = kill_q;
    skid_valid_d  = skid_valid_q;
    skid_pc_d     = skid_pc_q;
    skid_instr_d  = skid_instr_q;
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    rsp_wr        = 1'b0;

    if (redirect) begin
      // Flush: IF/ID becomes a bubble (pc kept), skid dropped, refetch.
      if_id_valid_d = 1'b0;
      if_id_instr_d = NOP_INSTR;
      skid_valid_d  = 1'b0;
      pc_d          = redirect_pc;
      if (rsp) begin
        // The in-flight response is the wrong-path one: drop it directly.
        kill_d  = 1'b0;
        state_d = ST_ISSUE;
      end else if ((state_q == ST_WAIT) || accept) begin
        // A response is still coming back; mark it for discard.
        kill_d  = 1'b1;
        state_d = ST_WAIT;
      end else begin
        state_d = ST_ISSUE;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ISSUE;

        ST_ISSUE: begin
          // Accept is allowed under hold: the skid buffer absorbs the reply.
          if (imem_gnt) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + PC_W'(4);
            state_d  = ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (rsp) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = ST_ISSUE;
            end else if (!if_id_valid_q || !if_id_hold) begin
              rsp_wr        = 1'b1;
              if_id_valid_d = 1'b1;
              if_id_pc_d    = req_pc_q;
              if_id_instr_d = imem_rdata;
              state_d       = ST_ISSUE;
            end else begin
              rsp_wr       = 1'b1;
              skid_valid_d = 1'b1;
              skid_pc_d    = req_pc_q;
              skid_instr_d = imem_rdata;
              state_d      = ST_FULL;
            end
          end
        end

        ST_FULL: begin
          if (!if_id_hold) state_d = ST_ISSUE;
        end

        default: state_d = ST_IDLE;
      endcase

      // IF/ID advances when not held and not just written by a response:
      // drain the skid if occupied, otherwise insert a bubble.
      if (!rsp_wr && !if_id_hold) begin
        if (skid_valid_q) begin
          if_id_valid_d = 1'b1;
          if_id_pc_d    = skid_pc_q;
          if_id_instr_d = skid_instr_q;
          skid_valid_d  = 1'b0;
        end else begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP_INSTR;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      kill_q        <= 1'b0;
      skid_valid_q  <= 1'b0;
      skid_pc_q     <= '0;
      skid_instr_q  <= NOP_INSTR;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      kill_q        <= kill_d;
      skid_valid_q  <= skid_valid_d;
      skid_pc_q     <= skid_pc_d;
      skid_instr_q  <= skid_instr_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_if_id_stage
//
// Directed bench for fetch_if_id_stage. A small memory model answers each
// accepted request after 'lat' cycles with a PC-tagged word. Outputs are
// sampled 1 time unit after each rising edge and compared with hand-derived
// values.
// -----------------------------------------------------------------------------
module tb_fetch_if_id_stage;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  logic               clk = 1'b0;
  logic               rst;
  logic               if_id_hold;
  logic               redirect;
  logic [PC_W-1:0]    redirect_pc;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_id_valid;
  logic [PC_W-1:0]    if_id_pc;
  logic [INSTR_W-1:0] if_id_instr;

  fetch_if_id_stage #(
    .PC_W     (PC_W),
    .INSTR_W  (INSTR_W),
    .RESET_PC ('0),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_id_hold (if_id_hold),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .if_id_valid(if_id_valid),
    .if_id_pc   (if_id_pc),
    .if_id_instr(if_id_instr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory model state.
  int              lat = 1;
  logic            pend = 1'b0;
  int              cnt = 0;
  logic [PC_W-1:0] paddr = '0;

  function automatic logic [INSTR_W-1:0] tag(input logic [PC_W-1:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock: sample the handshake before the edge, then update the memory
  // model so the next cycle's rvalid/rdata are in place.
  task automatic cycle();
    logic            acc;
    logic [PC_W-1:0] a;
    acc = imem_req & imem_gnt;
    a   = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (acc) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = a;
    end
    if (pend) begin
      if (cnt <= 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = tag(paddr);
        pend        = 1'b0;
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic check_ifid(input string name, input logic v,
                            input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins);
    check({name, ".valid"}, 64'(if_id_valid), 64'(v));
    check({name, ".pc"},    if_id_pc,         pc);
    check({name, ".instr"}, 64'(if_id_instr), 64'(ins));
  endtask

  initial begin
    rst = 1'b1; if_id_hold = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;

    // Reset values.
    cycle(); cycle();
    check("rst.req", 64'(imem_req), 64'd0);
    check_ifid("rst.ifid", 1'b0, 64'h0, NOP);
    rst = 1'b0;

    // Straight-line fetch: dead cycle, then ISSUE/WAIT alternating.
    check("idle.req", 64'(imem_req), 64'd0);
    cycle();
    check("issue0.req", 64'(imem_req), 64'd1);
    check("issue0.addr", imem_addr, 64'h0);
    cycle();
    check("wait0.req", 64'(imem_req), 64'd0);
    cycle();
    check_ifid("pc0", 1'b1, 64'h0, tag(64'h0));
    check("issue4.addr", imem_addr, 64'h4);
    cycle();
    check("bubble0.valid", 64'(if_id_valid), 64'd0);
    cycle();
    check_ifid("pc4", 1'b1, 64'h4, tag(64'h4));

    // Hold for 4 cycles while 0x8 is fetched: it lands in the skid buffer.
    if_id_hold = 1'b1;
    cycle();
    check_ifid("hold1", 1'b1, 64'h4, tag(64'h4));
    cycle();
    check_ifid("hold2", 1'b1, 64'h4, tag(64'h4));
    check("hold2.req", 64'(imem_req), 64'd0);
    cycle();
    check("hold3.req", 64'(imem_req), 64'd0);
    cycle();
    check("hold4.req", 64'(imem_req), 64'd0);
    check("hold4.pc", if_id_pc, 64'h4);
    if_id_hold = 1'b0;
    cycle();
    check_ifid("skid8", 1'b1, 64'h8, tag(64'h8));
    check("resume.req", 64'(imem_req), 64'd1);
    check("resume.addr", imem_addr, 64'hC);
    cycle();
    cycle();
    check_ifid("pcC", 1'b1, 64'hC, tag(64'hC));

    // Redirect while waiting on 0x10 (2-cycle latency): response is killed.
    lat = 2;
    cycle();
    redirect = 1'b1; redirect_pc = 64'h100;
    cycle();
    check_ifid("redir1", 1'b0, 64'hC, NOP);
    check("redir1.req", 64'(imem_req), 64'd0);
    redirect = 1'b0;
    cycle();
    check("kill.valid", 64'(if_id_valid), 64'd0);
    check("kill.req", 64'(imem_req), 64'd1);
    check("kill.addr", imem_addr, 64'h100);
    lat = 1;
    cycle();
    cycle();
    check_ifid("pc100", 1'b1, 64'h100, tag(64'h100));

    // Redirect in the same cycle as rvalid, with hold asserted.
    if_id_hold = 1'b1;
    cycle();
    check("hold100.pc", if_id_pc, 64'h100);
    redirect = 1'b1; redirect_pc = 64'h200;
    cycle();
    check_ifid("redir2", 1'b0, 64'h100, NOP);
    check("redir2.req", 64'(imem_req), 64'd1);
    check("redir2.addr", imem_addr, 64'h200);
    redirect = 1'b0; if_id_hold = 1'b0;

    // gnt low for 5 cycles: address stable, IF/ID bubbles (skid was cleared).
    imem_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("nognt.addr", imem_addr, 64'h200);
      check("nognt.req", 64'(imem_req), 64'd1);
      check("nognt.valid", 64'(if_id_valid), 64'd0);
    end
    imem_gnt = 1'b1;
    cycle();
    cycle();
    check_ifid("pc200", 1'b1, 64'h200, tag(64'h200));

    // Reset during WAIT; the late response must be ignored.
    lat = 3;
    cycle();
    rst = 1'b1;
    cycle();
    check("rst2.req", 64'(imem_req), 64'd0);
    check_ifid("rst2.ifid", 1'b0, 64'h0, NOP);
    rst = 1'b0; lat = 1;
    cycle();
    check("restart.req", 64'(imem_req), 64'd1);
    check("restart.addr", imem_addr, 64'h0);
    cycle();
    check("late.valid", 64'(if_id_valid), 64'd0);
    cycle();
    check_ifid("restart.pc0", 1'b1, 64'h0, tag(64'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
